game_event_logger: RTL and testbench

//  Downstream consumer of the multimode up/down counter game outputs (winner, loser, gameover, who, counter).

---
 rtl/game_event_logger.sv | 206 ++++++++++++++++++++
 tb/tb_game_event_logger.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_event_logger.sv
// -----------------------------------------------------------------------------
// game_event_logger
//
// Watches the win / lose / game-over flags of the up/down counter game. Each
// rising edge becomes one event record. Records are queued in a small FIFO that
// a valid/ready consumer drains. The block also keeps saturating totals of
// rounds won and lost, games completed and events lost to backpressure.
//
// Optional feature: define GAME_LOG_TIMESTAMP_EN to prefix each record with the
// value of a free-running TS_W-bit cycle counter, sampled when the record is
// pushed.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   counter     counter value from the counter stage; 1 ends a round
//   winner      round-won flag (level)
//   loser       round-lost flag (level)
//   gameover    game-over flag (level)
//   who         2'b10 winner side, 2'b01 loser side; valid with gameover
//   evt_valid   head record available
//   evt_ready   consumer accepts the head record
//   evt_data    {[ts,] type[1:0], who[1:0], 2'b00, round[3:0]}
//   level       FIFO occupancy
//   win_total   rounds won (saturating)
//   lose_total  rounds lost (saturating)
//   games       games completed (saturating)
//   drops       events lost (saturating)
//   overflow    sticky, set on the first drop
// -----------------------------------------------------------------------------
module game_event_logger #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 8,
   parameter int TS_W  = 16,
`ifdef GAME_LOG_TIMESTAMP_EN
   localparam int EW = 10 + TS_W,
`else
   localparam int EW = 10,
`endif
   localparam int LW = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [3:0]       counter,
   input  logic             winner,
   input  logic             loser,
   input  logic             gameover,
   input  logic [1:0]       who,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [EW-1:0]    evt_data,
   output logic [LW-1:0]    level,
   output logic [CNT_W-1:0] win_total,
   output logic [CNT_W-1:0] lose_total,
   output logic [CNT_W-1:0] games,
   output logic [CNT_W-1:0] drops,
   output logic             overflow
);

   localparam int AW = LW - 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1) begin : g_bad_param
      $error("game_event_logger: DEPTH must be a power of 2 >= 2, TS_W >= 1");
   end

   typedef enum logic [1:0] {PLAY, ROUND_END, GAME_END} state_t;

   state_t        state;
   logic          armed;
   logic          prev_win, prev_lose, prev_go;
   logic          p_go, p_win, p_lose;
   logic [3:0]    round;
   logic [LW-1:0] wr_ptr, rd_ptr;
   logic [EW-1:0] mem [DEPTH];

   logic          win_edge, lose_edge, go_edge;
   logic          full, pop, space;
   logic          push_go, push_win, push_lose, push;
   logic          spurious;
   logic          go_drop, win_drop, lose_drop;
   logic [1:0]    n_drop;
   logic [CNT_W:0] drop_sum;
   logic [9:0]    record;
   logic [EW-1:0] entry;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // armed stays low for the first clock after reset so that a flag already
   // high at reset release is captured into prev_* without counting as an edge.
   assign win_edge  = armed & winner   & ~prev_win;
   assign lose_edge = armed & loser    & ~prev_lose;
   assign go_edge   = armed & gameover & ~prev_go;

   assign level     = wr_ptr - rd_ptr;
   assign full      = (level == LW'(DEPTH));
   assign evt_valid = (level != '0);
   assign pop       = evt_valid & evt_ready;
   // A pop frees a slot in the same cycle, so a full FIFO can still accept.
   assign space     = ~full | pop;

   assign push_go   = space & p_go;
   assign push_win  = space & ~p_go & p_win;
   assign push_lose = space & ~p_go & ~p_win & p_lose;
   assign push      = push_go | push_win | push_lose;

   // A round result seen after a round has already ended is spurious.
   assign spurious  = (state != PLAY);
   assign go_drop   = go_edge & p_go & ~push_go;
   assign win_drop  = win_edge & (spurious | (p_win & ~push_win));
   assign lose_drop = lose_edge & (spurious | (p_lose & ~push_lose));

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      n_drop   = 2'd0;
      n_drop   = {1'b0, go_drop} + {1'b0, win_drop} + {1'b0, lose_drop};
      drop_sum = {1'b0, drops} + {{(CNT_W-1){1'b0}}, n_drop};
      record   = {2'b10, 2'b00, 2'b00, round};
      if (push_go)       record = {2'b11, who,   2'b00, round};
      else if (push_win) record = {2'b01, 2'b00, 2'b00, round};
   end

`ifdef GAME_LOG_TIMESTAMP_EN
   logic [TS_W-1:0] ts;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ts <= '0;
      else          ts <= ts + TS_W'(1);
   end

   assign entry = {ts, record};
`else
   assign entry = record;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         armed      <= 1'b0;
         prev_win   <= 1'b0;
         prev_lose  <= 1'b0;
         prev_go    <= 1'b0;
         p_go       <= 1'b0;
         p_win      <= 1'b0;
         p_lose     <= 1'b0;
         round      <= 4'd0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         win_total  <= '0;
         lose_total <= '0;
         games      <= '0;
         drops      <= '0;
         overflow   <= 1'b0;
      end else begin
         armed     <= 1'b1;
         prev_win  <= winner;
         prev_lose <= loser;
         prev_go   <= gameover;

         // A bit cleared by a push this cycle may be re-armed by a new edge.
         p_go   <= (p_go & ~push_go) | go_edge;
         p_win  <= (p_win & ~push_win) | (win_edge & ~spurious);
         p_lose <= (p_lose & ~push_lose) | (lose_edge & ~spurious);

         if (push_go)                    round <= 4'd0;
         else if (push_win | push_lose)  round <= round + 4'd1;

         if (push_win)  win_total  <= sat_inc(win_total);
         if (push_lose) lose_total <= sat_inc(lose_total);
         if (push_go)   games      <= sat_inc(games);

         drops    <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
         overflow <= overflow | (n_drop != 2'd0);

         if (push) wr_ptr <= wr_ptr + LW'(1);
         if (pop)  rd_ptr <= rd_ptr + LW'(1);
      end
   end

   // NOTE: the storage array has no reset; the pointers define which entries
   // are meaningful, and evt_data is forced to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= entry;
   end

   assign evt_data = evt_valid ? mem[rd_ptr[AW-1:0]] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= PLAY;
      end else if (push_go) begin
         state <= GAME_END;
      end else begin
         case (state)
            PLAY:      if (push_win | push_lose) state <= ROUND_END;
            ROUND_END: if (counter == 4'd1)      state <= PLAY;
            GAME_END:  if (!gameover)            state <= PLAY;
            default:                             state <= PLAY;
         endcase
      end
   end

endmodule

// File: tb/tb_game_event_logger.sv
// -----------------------------------------------------------------------------
// tb_game_event_logger
//
// Directed bench for game_event_logger with DEPTH=8. Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge. Define
// GAME_LOG_TIMESTAMP_EN for both files to exercise the timestamp field.
// -----------------------------------------------------------------------------
module tb_game_event_logger;

   localparam int DEPTH = 8;
   localparam int CNT_W = 8;
   localparam int TS_W  = 16;
`ifdef GAME_LOG_TIMESTAMP_EN
   localparam int EW = 10 + TS_W;
`else
   localparam int EW = 10;
`endif
   localparam int LW = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [3:0]       counter;
   logic             winner, loser, gameover;
   logic [1:0]       who;
   logic             evt_valid;
   logic             evt_ready;
   logic [EW-1:0]    evt_data;
   logic [LW-1:0]    level;
   logic [CNT_W-1:0] win_total, lose_total, games, drops;
   logic             overflow;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   game_event_logger #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .counter    (counter),
      .winner     (winner),
      .loser      (loser),
      .gameover   (gameover),
      .who        (who),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_data   (evt_data),
      .level      (level),
      .win_total  (win_total),
      .lose_total (lose_total),
      .games      (games),
      .drops      (drops),
      .overflow   (overflow)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      counter   = 4'd1;
      winner    = 1'b0;
      loser     = 1'b0;
      gameover  = 1'b0;
      who       = 2'b00;
      evt_ready = 1'b0;
      reset_n   = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
   endtask

   // One isolated round flag pulse; with counter==1 the FSM is back in PLAY
   // before the next pulse.
   task automatic pulse(input bit is_win);
      if (is_win) winner = 1'b1;
      else        loser  = 1'b1;
      tick();
      winner = 1'b0;
      loser  = 1'b0;
      tick();
      tick();
   endtask

   function automatic logic [9:0] exp_round_rec(input int k);
      logic [3:0] r;
      r = 4'(k);
      return {((k % 2) == 0) ? 2'b01 : 2'b10, 4'b0000, r};
   endfunction

   task automatic test_reset();
      counter   = 4'd0;
      winner    = 1'b1;
      loser     = 1'b0;
      gameover  = 1'b0;
      who       = 2'b00;
      evt_ready = 1'b1;
      reset_n   = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (3) tick();
      n_checks++;
      if (evt_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid: got %0b want 0", evt_valid);
      end
      n_checks++;
      if (level !== '0) begin
         n_fail++; $display("FAIL reset_level: got %0d want 0", level);
      end
      n_checks++;
      if ({win_total, lose_total, games, drops} !== '0) begin
         n_fail++; $display("FAIL reset_totals: got %0h %0h %0h %0h want 0", win_total, lose_total, games, drops);
      end
      n_checks++;
      if (overflow !== 1'b0 || evt_data !== '0) begin
         n_fail++; $display("FAIL reset_ovf_data: got %0b %0h want 0 0", overflow, evt_data);
      end
      winner = 1'b0;
      tick();
   endtask

   task automatic test_win_round();
      do_reset();
      counter   = 4'd0;
      evt_ready = 1'b1;
      winner    = 1'b1;
      tick();
      n_checks++;
      if (evt_valid !== 1'b0) begin
         n_fail++; $display("FAIL win_early_valid: got %0b want 0", evt_valid);
      end
      winner = 1'b0;
      tick();
      n_checks++;
      if (evt_valid !== 1'b1 || evt_data[9:0] !== 10'b01_00_00_0000) begin
         n_fail++; $display("FAIL win_record: got v=%0b d=%b want v=1 d=0100000000", evt_valid, evt_data[9:0]);
      end
      n_checks++;
      if (win_total !== 8'd1) begin
         n_fail++; $display("FAIL win_total: got %0d want 1", win_total);
      end
      tick();
      n_checks++;
      if (evt_valid !== 1'b0) begin
         n_fail++; $display("FAIL win_popped: got %0b want 0", evt_valid);
      end
      // counter has not reached 1: a second win edge is spurious
      pulse(1'b1);
      n_checks++;
      if (drops !== 8'd1 || overflow !== 1'b1 || win_total !== 8'd1 || level !== '0) begin
         n_fail++; $display("FAIL win_spurious: got drops=%0d ovf=%0b win=%0d lvl=%0d want 1 1 1 0", drops, overflow, win_total, level);
      end
      counter = 4'd1;
      tick();
      tick();
      winner = 1'b1;
      tick();
      winner = 1'b0;
      tick();
      n_checks++;
      if (evt_valid !== 1'b1 || evt_data[9:0] !== 10'b01_00_00_0001 || win_total !== 8'd2) begin
         n_fail++; $display("FAIL win_after_play: got v=%0b d=%b win=%0d want 1 0100000001 2", evt_valid, evt_data[9:0], win_total);
      end
      tick();
   endtask

   task automatic test_game_over();
      do_reset();
      evt_ready = 1'b1;
      pulse(1'b1);
      winner   = 1'b1;
      gameover = 1'b1;
      who      = 2'b10;
      tick();
      winner = 1'b0;
      tick();
      n_checks++;
      if (evt_valid !== 1'b1 || evt_data[9:0] !== 10'b11_10_00_0001) begin
         n_fail++; $display("FAIL go_first: got v=%0b d=%b want 1 1110000001", evt_valid, evt_data[9:0]);
      end
      n_checks++;
      if (games !== 8'd1) begin
         n_fail++; $display("FAIL go_games: got %0d want 1", games);
      end
      tick();
      n_checks++;
      if (evt_valid !== 1'b1 || evt_data[9:0] !== 10'b01_00_00_0000 || win_total !== 8'd2) begin
         n_fail++; $display("FAIL go_win_after: got v=%0b d=%b win=%0d want 1 0100000000 2", evt_valid, evt_data[9:0], win_total);
      end
      tick();
      n_checks++;
      if (evt_valid !== 1'b0 || games !== 8'd1) begin
         n_fail++; $display("FAIL go_drained: got v=%0b games=%0d want 0 1", evt_valid, games);
      end
      gameover = 1'b0;
      who      = 2'b00;
      tick();
   endtask

   task automatic test_backpressure();
      logic [EW-1:0] head;
      do_reset();
      for (int k = 0; k < 9; k++) pulse((k % 2) == 0);
      n_checks++;
      if (level !== LW'(8) || drops !== 8'd0) begin
         n_fail++; $display("FAIL bp_full: got lvl=%0d drops=%0d want 8 0", level, drops);
      end
      n_checks++;
      if (win_total !== 8'd4 || lose_total !== 8'd4) begin
         n_fail++; $display("FAIL bp_totals: got win=%0d lose=%0d want 4 4", win_total, lose_total);
      end
      head = evt_data;
      tick();
      tick();
      n_checks++;
      if (evt_data !== head || evt_data[9:0] !== exp_round_rec(0)) begin
         n_fail++; $display("FAIL bp_stable: got %b want %b", evt_data[9:0], exp_round_rec(0));
      end
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      n_checks++;
      if (level !== LW'(8) || win_total !== 8'd5) begin
         n_fail++; $display("FAIL bp_pending_push: got lvl=%0d win=%0d want 8 5", level, win_total);
      end
      evt_ready = 1'b1;
      for (int k = 1; k < 9; k++) begin
         n_checks++;
         if (evt_valid !== 1'b1 || evt_data[9:0] !== exp_round_rec(k)) begin
            n_fail++; $display("FAIL bp_drain_%0d: got v=%0b d=%b want 1 %b", k, evt_valid, evt_data[9:0], exp_round_rec(k));
         end
         tick();
      end
      n_checks++;
      if (evt_valid !== 1'b0 || level !== '0) begin
         n_fail++; $display("FAIL bp_empty: got v=%0b lvl=%0d want 0 0", evt_valid, level);
      end
   endtask

   task automatic test_drop();
      do_reset();
      for (int k = 0; k < 8; k++) pulse((k % 2) == 0);
      pulse(1'b1);
      n_checks++;
      if (drops !== 8'd0 || overflow !== 1'b0) begin
         n_fail++; $display("FAIL drop_none_yet: got drops=%0d ovf=%0b want 0 0", drops, overflow);
      end
      pulse(1'b1);
      n_checks++;
      if (drops !== 8'd1 || overflow !== 1'b1 || win_total !== 8'd4) begin
         n_fail++; $display("FAIL drop_hit: got drops=%0d ovf=%0b win=%0d want 1 1 4", drops, overflow, win_total);
      end
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      tick();
      n_checks++;
      if (win_total !== 8'd5 || level !== LW'(8) || drops !== 8'd1 || overflow !== 1'b1) begin
         n_fail++; $display("FAIL drop_after_pop: got win=%0d lvl=%0d drops=%0d ovf=%0b want 5 8 1 1", win_total, level, drops, overflow);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int k = 0; k < 5; k++) pulse((k % 2) == 0);
      n_checks++;
      if (level !== LW'(5) || win_total !== 8'd3 || lose_total !== 8'd2) begin
         n_fail++; $display("FAIL mid_fill: got lvl=%0d win=%0d lose=%0d want 5 3 2", level, win_total, lose_total);
      end
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      n_checks++;
      if (level !== '0 || evt_valid !== 1'b0) begin
         n_fail++; $display("FAIL mid_cleared: got lvl=%0d v=%0b want 0 0", level, evt_valid);
      end
      n_checks++;
      if ({win_total, lose_total, games, drops} !== '0 || overflow !== 1'b0) begin
         n_fail++; $display("FAIL mid_totals: got %0d %0d %0d %0d ovf=%0b want 0", win_total, lose_total, games, drops, overflow);
      end
      winner = 1'b1;
      tick();
      winner = 1'b0;
      tick();
      n_checks++;
      if (evt_valid !== 1'b1 || evt_data[9:0] !== 10'b01_00_00_0000) begin
         n_fail++; $display("FAIL mid_next_rec: got v=%0b d=%b want 1 0100000000", evt_valid, evt_data[9:0]);
      end
`ifdef GAME_LOG_TIMESTAMP_EN
      n_checks++;
      if (evt_data[EW-1:10] !== TS_W'(2)) begin
         n_fail++; $display("FAIL mid_timestamp: got %0d want 2", evt_data[EW-1:10]);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_win_round();
      test_game_over();
      test_backpressure();
      test_drop();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
